pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_seq_pkg.sv | 35 +++
 rtl/pc_next_calc.sv | 51 +++++
 rtl/pc_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared definitions for the PC sequencer: state encoding, next-PC source
// codes and the sequential PC step.
package pc_seq_pkg;

   // Sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_EXEC   = 3'd2,
      ST_UPDATE = 3'd3,
      ST_HALT   = 3'd4
   } state_t;

   // Next-PC source codes carried on NextSel.
   typedef enum logic [1:0] {
      NS_SEQ    = 2'b00,
      NS_BRANCH = 2'b01,
      NS_JUMP   = 2'b10,
      NS_HALT   = 2'b11
   } nextsel_t;

   localparam int          PC_W    = 16;
   localparam logic [15:0] PC_STEP = 16'd2;

   // Sequential successor of a PC; 16-bit modulo so 0xFFFE wraps to 0x0000.
   function automatic logic [15:0] pc_add_step(input logic [15:0] pc);
      return pc + PC_STEP;
   endfunction

   // Instruction addresses are halfword aligned: clear bit 0 of a target.
   function automatic logic [15:0] align_target(input logic [15:0] tgt);
      return {tgt[15:1], 1'b0};
   endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential step, conditional branch or
// jump. Also reports whether the target was the chosen source so the
// sequencer can flag odd targets.
module pc_next_calc
   import pc_seq_pkg::*;
(
   input  logic [15:0] pcout,
   input  logic [1:0]  nextsel,
   input  logic        brtaken,
   input  logic [15:0] target,
   output logic [15:0] pcnext,
   output logic        target_used
);

   logic [15:0] seq_pc;
   logic [15:0] tgt_pc;

   assign seq_pc = pc_add_step(pcout);
   assign tgt_pc = align_target(target);

   // Pick the source; halt falls back to the sequential value, which the
   // sequencer never writes anyway.
   always_comb begin
      pcnext      = seq_pc;
      target_used = 1'b0;
      case (nextsel)
         NS_SEQ: begin
            pcnext      = seq_pc;
            target_used = 1'b0;
         end
         NS_BRANCH: begin
            if (brtaken) begin
               pcnext      = tgt_pc;
               target_used = 1'b1;
            end else begin
               pcnext      = seq_pc;
               target_used = 1'b0;
            end
         end
         NS_JUMP: begin
            pcnext      = tgt_pc;
            target_used = 1'b1;
         end
         default: begin
            pcnext      = seq_pc;
            target_used = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction sequencer: fetch handshake, execute wait, PC update and halt.
// Strobes are decoded from the state so the asynchronous reset clears them
// immediately; PCIn, RetireCnt and Misalign are registered.
module pc_sequencer
   import pc_seq_pkg::*;
(
   input  logic        CLK,
   input  logic        Reset,
   input  logic        Start,
   input  logic [15:0] PCout,
   input  logic        InstrAck,
   input  logic        Done,
   input  logic        Stall,
   input  logic [1:0]  NextSel,
   input  logic        BrTaken,
   input  logic [15:0] Target,
   output logic        InstrReq,
   output logic        IRWrite,
   output logic        PCWrite,
   output logic [15:0] PCIn,
   output logic        Halted,
   output logic        Misalign,
   output logic [15:0] RetireCnt
);

   state_t      state_reg;
   state_t      state_next;

   logic [15:0] pcin_reg;
   logic [15:0] retire_reg;
   logic        misalign_reg;

   logic [15:0] pc_calc;
   logic        target_used;
   logic        done_sampled;
   logic        halt_sel;

   pc_next_calc u_next (
      .pcout       (PCout),
      .nextsel     (NextSel),
      .brtaken     (BrTaken),
      .target      (Target),
      .pcnext      (pc_calc),
      .target_used (target_used)
   );

   // Done counts only while executing and not held by Stall.
   assign done_sampled = (state_reg == ST_EXEC) && Done && !Stall;
   assign halt_sel     = (NextSel == NS_HALT);

   // State register.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and strobe decode.
   always_comb begin
      state_next = state_reg;
      InstrReq   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      Halted     = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (Start) begin
               state_next = ST_FETCH;
            end
         end
         ST_FETCH: begin
            InstrReq = 1'b1;
            if (InstrAck) begin
               IRWrite    = 1'b1;
               state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (done_sampled) begin
               state_next = halt_sel ? ST_HALT : ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            PCWrite    = 1'b1;
            state_next = ST_FETCH;
         end
         ST_HALT: begin
            Halted = 1'b1;
            if (Start) begin
               state_next = ST_FETCH;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Capture the next PC on a non-halting Done; it is held for UPDATE and
   // beyond until the next instruction retires.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         pcin_reg <= 16'h0000;
      end else if (done_sampled && !halt_sel) begin
         pcin_reg <= pc_calc;
      end
   end

   // Retired-instruction counter; halts retire too. Wraps naturally.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         retire_reg <= 16'h0000;
      end else if (done_sampled) begin
         retire_reg <= retire_reg + 16'd1;
      end
   end

   // Sticky flag for any odd target that actually steered the PC.
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         misalign_reg <= 1'b0;
      end else if (done_sampled && !halt_sel && target_used && Target[0]) begin
         misalign_reg <= 1'b1;
      end
   end

   assign PCIn      = pcin_reg;
   assign RetireCnt = retire_reg;
   assign Misalign  = misalign_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scenarios for pc_sequencer with a scoreboard of expected
// PCIn/RetireCnt pairs, pushed when Done is driven and popped on PCWrite.
module tb_pc_sequencer;

   logic        CLK;
   logic        Reset;
   logic        Start;
   logic [15:0] PCout;
   logic        InstrAck;
   logic        Done;
   logic        Stall;
   logic [1:0]  NextSel;
   logic        BrTaken;
   logic [15:0] Target;
   logic        InstrReq;
   logic        IRWrite;
   logic        PCWrite;
   logic [15:0] PCIn;
   logic        Halted;
   logic        Misalign;
   logic [15:0] RetireCnt;

   typedef struct {
      logic [15:0] pcin;
      logic [15:0] retire;
   } exp_t;

   exp_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [15:0] retire_model = 16'h0000;

   pc_sequencer dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .Start     (Start),
      .PCout     (PCout),
      .InstrAck  (InstrAck),
      .Done      (Done),
      .Stall     (Stall),
      .NextSel   (NextSel),
      .BrTaken   (BrTaken),
      .Target    (Target),
      .InstrReq  (InstrReq),
      .IRWrite   (IRWrite),
      .PCWrite   (PCWrite),
      .PCIn      (PCIn),
      .Halted    (Halted),
      .Misalign  (Misalign),
      .RetireCnt (RetireCnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b0; Start = 1'b0; PCout = 16'h0000; InstrAck = 1'b0;
      Done = 1'b0; Stall = 1'b0; NextSel = 2'b00; BrTaken = 1'b0; Target = 16'h0000;
      #2;
      checks++;
      if ({InstrReq, IRWrite, PCWrite, Halted, Misalign} !== 5'b0 || PCIn !== 16'h0 || RetireCnt !== 16'h0) begin
         failures++;
         $display("FAIL reset_async: strobes=%b PCIn=%h RetireCnt=%h required all 0",
                  {InstrReq, IRWrite, PCWrite, Halted, Misalign}, PCIn, RetireCnt);
      end
      tick();
      Reset = 1'b1;
      retire_model = 16'h0000;
      for (int i = 0; i < 10; i++) tick();
      checks++;
      if ({InstrReq, IRWrite, PCWrite, Halted, Misalign} !== 5'b0 || PCIn !== 16'h0 || RetireCnt !== 16'h0) begin
         failures++;
         $display("FAIL reset_idle: strobes=%b PCIn=%h RetireCnt=%h required all 0",
                  {InstrReq, IRWrite, PCWrite, Halted, Misalign}, PCIn, RetireCnt);
      end
      $display("reset: idle after 10 cycles, InstrReq=%b", InstrReq);
   endtask

   // Pulse Start for one cycle (from IDLE or HALT).
   task automatic pulse_start();
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   // Wait (bounded) for FETCH, then acknowledge and enter EXEC.
   task automatic fetch(input string name);
      int n;
      n = 0;
      while (InstrReq !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if (InstrReq !== 1'b1) begin
         failures++;
         $display("FAIL %s_fetch_timeout: InstrReq=%b required 1", name, InstrReq);
      end
      InstrAck = 1'b1;
      #1;
      checks++;
      if (IRWrite !== 1'b1) begin
         failures++;
         $display("FAIL %s_irwrite: IRWrite=%b required 1", name, IRWrite);
      end
      tick();
      InstrAck = 1'b0;
   endtask

   // Present Done in EXEC, then pop the scoreboard on PCWrite and check
   // that PCWrite lasts exactly one cycle with FETCH following.
   task automatic exec_done(input string name, input logic [15:0] pc, input logic [1:0] sel,
                            input logic br, input logic [15:0] tgt, input logic [15:0] exp_pc);
      exp_t e;
      int   n;
      PCout = pc; NextSel = sel; BrTaken = br; Target = tgt; Done = 1'b1;
      retire_model = retire_model + 16'd1;
      e.pcin = exp_pc;
      e.retire = retire_model;
      exp_q.push_back(e);
      tick();
      Done = 1'b0;
      n = 0;
      while (PCWrite !== 1'b1 && n < 5) begin
         tick();
         n++;
      end
      checks++;
      if (PCWrite !== 1'b1 || n != 0) begin
         failures++;
         $display("FAIL %s_pcwrite_latency: PCWrite=%b after %0d extra cycles required 1 after 0", name, PCWrite, n);
      end
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (PCIn !== e.pcin || RetireCnt !== e.retire) begin
            failures++;
            $display("FAIL %s_update: PCIn=%h RetireCnt=%h required PCIn=%h RetireCnt=%h",
                     name, PCIn, RetireCnt, e.pcin, e.retire);
         end
      end
      tick();
      checks++;
      if (PCWrite !== 1'b0 || InstrReq !== 1'b1) begin
         failures++;
         $display("FAIL %s_after_update: PCWrite=%b InstrReq=%b required 0 and 1", name, PCWrite, InstrReq);
      end
      $display("%s: PCout=%h sel=%b br=%b tgt=%h -> PCIn=%h RetireCnt=%h Misalign=%b",
               name, pc, sel, br, tgt, PCIn, RetireCnt, Misalign);
   endtask

   task automatic test_sequential();
      pulse_start();
      fetch("seq");
      exec_done("seq", 16'h0000, 2'b00, 1'b0, 16'h0000, 16'h0002);
      // Sit in FETCH without an ack: no further PCWrite may appear.
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (PCWrite !== 1'b0) begin
            failures++;
            $display("FAIL seq_single_pulse: PCWrite=%b required 0", PCWrite);
         end
      end
   endtask

   task automatic test_branch();
      fetch("br_nt");
      exec_done("br_nt", 16'h0010, 2'b01, 1'b0, 16'h0040, 16'h0012);
      fetch("br_t");
      exec_done("br_t", 16'h0010, 2'b01, 1'b1, 16'h0040, 16'h0040);
      checks++;
      if (Misalign !== 1'b0) begin
         failures++;
         $display("FAIL br_misalign: Misalign=%b required 0", Misalign);
      end
   endtask

   task automatic test_jump_wrap();
      fetch("jump_odd");
      exec_done("jump_odd", 16'h0100, 2'b10, 1'b0, 16'h0033, 16'h0032);
      checks++;
      if (Misalign !== 1'b1) begin
         failures++;
         $display("FAIL jump_misalign: Misalign=%b required 1", Misalign);
      end
      fetch("wrap");
      exec_done("wrap", 16'hFFFE, 2'b00, 1'b0, 16'h0000, 16'h0000);
      checks++;
      if (Misalign !== 1'b1) begin
         failures++;
         $display("FAIL wrap_misalign_sticky: Misalign=%b required 1", Misalign);
      end
   endtask

   task automatic test_stall();
      fetch("stall");
      PCout = 16'h0200; NextSel = 2'b00; Done = 1'b1; Stall = 1'b1;
      Start = 1'b1;            // ignored outside IDLE/HALT
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (PCWrite !== 1'b0 || RetireCnt !== retire_model || InstrReq !== 1'b0) begin
            failures++;
            $display("FAIL stall_hold: PCWrite=%b RetireCnt=%h InstrReq=%b required 0 %h 0",
                     PCWrite, RetireCnt, InstrReq, retire_model);
         end
      end
      Start = 1'b0;
      Stall = 1'b0;
      exec_done("stall", 16'h0200, 2'b00, 1'b0, 16'h0000, 16'h0202);
   endtask

   task automatic test_halt();
      logic [15:0] pc_hold;
      pc_hold = PCIn;
      fetch("halt");
      PCout = 16'h0300; NextSel = 2'b11; Done = 1'b1;
      retire_model = retire_model + 16'd1;
      tick();
      Done = 1'b0;
      checks++;
      if (Halted !== 1'b1 || PCWrite !== 1'b0 || RetireCnt !== retire_model || PCIn !== pc_hold) begin
         failures++;
         $display("FAIL halt_enter: Halted=%b PCWrite=%b RetireCnt=%h PCIn=%h required 1 0 %h %h",
                  Halted, PCWrite, RetireCnt, PCIn, retire_model, pc_hold);
      end
      tick();
      checks++;
      if (Halted !== 1'b1 || PCWrite !== 1'b0) begin
         failures++;
         $display("FAIL halt_hold: Halted=%b PCWrite=%b required 1 0", Halted, PCWrite);
      end
      pulse_start();
      checks++;
      if (InstrReq !== 1'b1 || Halted !== 1'b0 || PCIn !== pc_hold) begin
         failures++;
         $display("FAIL halt_resume: InstrReq=%b Halted=%b PCIn=%h required 1 0 %h", InstrReq, Halted, PCIn, pc_hold);
      end
      $display("halt: retired=%h resumed InstrReq=%b", RetireCnt, InstrReq);
      // Asynchronous reset mid-FETCH, away from any clock edge.
      #1;
      Reset = 1'b0;
      #1;
      checks++;
      if (InstrReq !== 1'b0 || RetireCnt !== 16'h0 || Misalign !== 1'b0 || PCIn !== 16'h0) begin
         failures++;
         $display("FAIL reset_in_fetch: InstrReq=%b RetireCnt=%h Misalign=%b PCIn=%h required 0 0 0 0",
                  InstrReq, RetireCnt, Misalign, PCIn);
      end
      tick();
      Reset = 1'b1;
      retire_model = 16'h0000;
      InstrAck = 1'b1;         // ignored in IDLE
      for (int i = 0; i < 3; i++) tick();
      InstrAck = 1'b0;
      checks++;
      if (InstrReq !== 1'b0 || IRWrite !== 1'b0) begin
         failures++;
         $display("FAIL reset_stays_idle: InstrReq=%b IRWrite=%b required 0 0", InstrReq, IRWrite);
      end
      $display("reset_in_fetch: InstrReq=%b", InstrReq);
   endtask

   task automatic test_back_to_back();
      pulse_start();
      fetch("b2b0");
      exec_done("b2b0", 16'h1000, 2'b00, 1'b0, 16'h0000, 16'h1002);
      fetch("b2b1");
      exec_done("b2b1", 16'h1002, 2'b10, 1'b0, 16'h2000, 16'h2000);
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_branch();
      test_jump_wrap();
      test_stall();
      test_halt();
      test_back_to_back();
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
